// File: rtl/act_mem_pingpong_ctrl.sv
// act_mem_pingpong_ctrl
// Double-buffer manager for the activation memory. A 32-bit writer fills one
// buffer while the PE-array read sequencer consumes the other. The block tracks
// per-buffer state, generates write addresses and hands full buffers to the
// consumer in strict fill order.
// Optional feature macro: PINGPONG_PERF_CNT_EN adds saturating stall counters
// (wr_stall_cnt_o, cons_stall_cnt_o).
module act_mem_pingpong_ctrl #(
   parameter int WORD_ADDR_W = 13,
   parameter int EXT_W       = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   wr_valid_i,
   input  logic                   wr_last_i,
   input  logic [EXT_W-1:0]       wr_data_i,
   output logic                   wr_ready_o,
   output logic                   mem_we_o,
   output logic [WORD_ADDR_W:0]   mem_waddr_o,
   output logic [EXT_W-1:0]       mem_wdata_o,
   input  logic                   cons_req_i,
   output logic                   cons_gnt_o,
   output logic                   cons_buf_o,
   output logic [WORD_ADDR_W:0]   cons_len_o,
   input  logic                   cons_done_i,
   output logic [3:0]             buf_state_o,
   output logic [1:0]             err_o
`ifdef PINGPONG_PERF_CNT_EN
   ,
   output logic [31:0]            wr_stall_cnt_o,
   output logic [31:0]            cons_stall_cnt_o
`endif
);

   localparam int LEN_W = WORD_ADDR_W + 1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FILL  = 2'd1,
      ST_FULL  = 2'd2,
      ST_BUSY  = 2'd3
   } buf_state_t;

   buf_state_t             r_state [2];
   logic                   r_wp;
   logic                   r_rp;
   logic [WORD_ADDR_W-1:0] r_wcnt;
   logic [LEN_W-1:0]       r_len [2];
   logic [1:0]             r_err;
   logic                   r_gnt;
   logic                   r_cons_buf;
   logic [LEN_W-1:0]       r_cons_len;

   logic w_wr_ready;
   logic w_wr_fire;
   logic w_close;
   logic w_any_busy;
   logic w_grant;
   logic w_done_ok;

   // The consumer only ever owns the buffer at rp, so BUSY is checked on both
   // entries for the grant guard and on rp for the release.
   assign w_wr_ready  = (r_state[r_wp] == ST_EMPTY) || (r_state[r_wp] == ST_FILL);
   assign w_wr_fire   = wr_valid_i & w_wr_ready;
   assign w_close     = w_wr_fire & (wr_last_i | (r_wcnt == {WORD_ADDR_W{1'b1}}));
   assign w_any_busy  = (r_state[0] == ST_BUSY) || (r_state[1] == ST_BUSY);
   assign w_grant     = cons_req_i & ~w_any_busy & (r_state[r_rp] == ST_FULL);
   assign w_done_ok   = cons_done_i & (r_state[r_rp] == ST_BUSY);

   assign wr_ready_o  = w_wr_ready;
   assign mem_we_o    = w_wr_fire;
   assign mem_waddr_o = {r_wp, r_wcnt};
   assign mem_wdata_o = wr_data_i;
   assign cons_gnt_o  = r_gnt;
   assign cons_buf_o  = r_cons_buf;
   assign cons_len_o  = r_cons_len;
   assign err_o       = r_err;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_state_out
         assign buf_state_o[2*gi +: 2] = r_state[gi];
      end
   endgenerate

   // Buffer bookkeeping: grant, release and write may land in the same cycle,
   // but they never target the same buffer, so their updates do not collide.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         r_state[0] <= ST_EMPTY;
         r_state[1] <= ST_EMPTY;
         r_len[0]   <= '0;
         r_len[1]   <= '0;
         r_wp       <= 1'b0;
         r_rp       <= 1'b0;
         r_wcnt     <= '0;
         r_err      <= '0;
         r_gnt      <= 1'b0;
         r_cons_buf <= 1'b0;
         r_cons_len <= '0;
      end else begin
         r_gnt <= w_grant;
         if (w_grant) begin
            r_state[r_rp] <= ST_BUSY;
            r_cons_buf    <= r_rp;
            r_cons_len    <= r_len[r_rp];
         end
         if (cons_done_i) begin
            if (w_done_ok) begin
               r_state[r_rp] <= ST_EMPTY;
               r_rp          <= ~r_rp;
            end else begin
               r_err[1] <= 1'b1;
            end
         end
         if (w_wr_fire) begin
            if (w_close) begin
               r_state[r_wp] <= ST_FULL;
               r_len[r_wp]   <= LEN_W'(r_wcnt) + LEN_W'(1);
               r_wcnt        <= '0;
               r_wp          <= ~r_wp;
               // a buffer closed because it ran out of space, not by the writer
               if (!wr_last_i) r_err[0] <= 1'b1;
            end else begin
               r_state[r_wp] <= ST_FILL;
               r_wcnt        <= r_wcnt + WORD_ADDR_W'(1);
            end
         end
      end
   end

`ifdef PINGPONG_PERF_CNT_EN
   logic [31:0] r_wr_stall_cnt;
   logic [31:0] r_cons_stall_cnt;

   assign wr_stall_cnt_o   = r_wr_stall_cnt;
   assign cons_stall_cnt_o = r_cons_stall_cnt;

   // Saturating stall counters for writer back-pressure and consumer starvation.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         r_wr_stall_cnt   <= '0;
         r_cons_stall_cnt <= '0;
      end else begin
         if (wr_valid_i && !w_wr_ready && (r_wr_stall_cnt != 32'hFFFF_FFFF))
            r_wr_stall_cnt <= r_wr_stall_cnt + 32'd1;
         if (cons_req_i && !w_grant && (r_cons_stall_cnt != 32'hFFFF_FFFF))
            r_cons_stall_cnt <= r_cons_stall_cnt + 32'd1;
      end
   end
`else
   // Stall counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_act_mem_pingpong_ctrl.sv
// Testbench for act_mem_pingpong_ctrl: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_act_mem_pingpong_ctrl;

   localparam int WAW   = 13;
   localparam int NWORD = 1 << WAW;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        wr_valid;
   logic        wr_last;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        mem_we;
   logic [WAW:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic        cons_req;
   logic        cons_gnt;
   logic        cons_buf;
   logic [WAW:0] cons_len;
   logic        cons_done;
   logic [3:0]  buf_state;
   logic [1:0]  err;
`ifdef PINGPONG_PERF_CNT_EN
   logic [31:0] wr_stall_cnt;
   logic [31:0] cons_stall_cnt;
`endif

   always #5 clk = ~clk;

   act_mem_pingpong_ctrl #(.WORD_ADDR_W(WAW), .EXT_W(32)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .flush_i     (flush),
      .wr_valid_i  (wr_valid),
      .wr_last_i   (wr_last),
      .wr_data_i   (wr_data),
      .wr_ready_o  (wr_ready),
      .mem_we_o    (mem_we),
      .mem_waddr_o (mem_waddr),
      .mem_wdata_o (mem_wdata),
      .cons_req_i  (cons_req),
      .cons_gnt_o  (cons_gnt),
      .cons_buf_o  (cons_buf),
      .cons_len_o  (cons_len),
      .cons_done_i (cons_done),
      .buf_state_o (buf_state),
      .err_o       (err)
`ifdef PINGPONG_PERF_CNT_EN
      ,
      .wr_stall_cnt_o   (wr_stall_cnt),
      .cons_stall_cnt_o (cons_stall_cnt)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: buffer ownership (0 empty, 1 filling, 2 full, 3 consumer),
   // plus a FIFO of closed buffers with their lengths in hand-over order.
   int  m_st [2];
   int  m_wp;
   int  m_wcnt;
   bit [1:0] m_err;
   bit  m_gnt;
   int  m_cbuf;
   int  m_clen;
   int  q_buf [$];
   int  q_len [$];
   bit  m_valid = 1'b0;
   longint m_wstall;
   longint m_cstall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int busy_idx();
      if (m_st[0] == 3) return 0;
      if (m_st[1] == 3) return 1;
      return -1;
   endfunction

   function automatic bit m_ready();
      return (m_st[m_wp] == 0) || (m_st[m_wp] == 1);
   endfunction

   // Advance the model over one rising edge using the inputs currently driven.
   task automatic model_update();
      bit fire;
      bit grant;
      int b;
      if (!rst_n || flush) begin
         m_st[0] = 0; m_st[1] = 0;
         m_wp = 0; m_wcnt = 0; m_err = 2'b00; m_gnt = 1'b0;
         m_cbuf = 0; m_clen = 0;
         q_buf.delete(); q_len.delete();
         m_wstall = 0; m_cstall = 0;
         m_valid = 1'b1;
         return;
      end
      if (!m_valid) return;
      fire  = wr_valid && m_ready();
      b     = busy_idx();
      grant = cons_req && (b < 0) && (q_buf.size() > 0);
      if (wr_valid && !m_ready()) m_wstall++;
      if (cons_req && !grant) m_cstall++;
      m_gnt = grant;
      if (grant) begin
         m_cbuf = q_buf.pop_front();
         m_clen = q_len.pop_front();
         m_st[m_cbuf] = 3;
      end
      if (cons_done) begin
         if (b >= 0) m_st[b] = 0;
         else m_err[1] = 1'b1;
      end
      if (fire) begin
         if (wr_last || m_wcnt == NWORD - 1) begin
            m_st[m_wp] = 2;
            q_buf.push_back(m_wp);
            q_len.push_back(m_wcnt + 1);
            if (!wr_last) m_err[0] = 1'b1;
            m_wcnt = 0;
            m_wp = 1 - m_wp;
         end else begin
            m_st[m_wp] = 1;
            m_wcnt++;
         end
      end
   endtask

   // One clock cycle: inputs are already driven at the falling edge.
   task automatic step();
      bit rdy;
      #1;
      if (m_valid) begin
         rdy = m_ready();
         chk("wr_ready", 64'(wr_ready), 64'(rdy));
         chk("mem_we", 64'(mem_we), 64'(wr_valid && rdy));
         if (wr_valid && rdy)
            chk("mem_waddr", 64'(mem_waddr), 64'(m_wp * NWORD + m_wcnt));
         chk("mem_wdata", 64'(mem_wdata), 64'(wr_data));
         chk("cons_gnt", 64'(cons_gnt), 64'(m_gnt));
         chk("cons_buf", 64'(cons_buf), 64'(m_cbuf));
         chk("cons_len", 64'(cons_len), 64'(m_clen));
         chk("buf_state", 64'(buf_state), 64'(m_st[1] * 4 + m_st[0]));
         chk("err", 64'(err), 64'(m_err));
`ifdef PINGPONG_PERF_CNT_EN
         chk("wr_stall_cnt", 64'(wr_stall_cnt), 64'(m_wstall));
         chk("cons_stall_cnt", 64'(cons_stall_cnt), 64'(m_cstall));
`endif
         if (m_gnt) $display("grant: buf=%0d len=%0d at %0t", cons_buf, cons_len, $time);
      end
      model_update();
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input bit l, input bit rq, input bit dn, input bit fl);
      wr_valid  = v;
      wr_last   = l;
      wr_data   = $urandom;
      cons_req  = rq;
      cons_done = dn;
      flush     = fl;
   endtask

   task automatic cyc(input bit v, input bit l, input bit rq, input bit dn, input bit fl);
      drive(v, l, rq, dn, fl);
      step();
   endtask

   task automatic do_reset(input bit rq);
      rst_n = 1'b0;
      cyc(0, 0, rq, 0, 0);
      cyc(0, 0, rq, 0, 0);
      rst_n = 1'b1;
   endtask

   bit req_r;
   bit dn_r;

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      @(negedge clk);

      // Scenario 1: four words, last on the fourth
      do_reset(1'b0);
      chk("t1_ready_after_reset", 64'(wr_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         drive(1, i == 3, 0, 0, 0);
         #1 chk("t1_addr", 64'(mem_waddr), 64'(i));
         step();
      end
      drive(0, 0, 0, 0, 0);
      #1 chk("t1_state", 64'(buf_state), 64'h2);
      step();
      $display("scenario 1 done");

      // Scenario 2: request held from reset, 2-word fill closes at t, grant at t+2
      do_reset(1'b1);
      cyc(1, 0, 1, 0, 0);
      cyc(1, 1, 1, 0, 0);
      drive(0, 0, 1, 0, 0);
      #1 chk("t2_no_gnt_t1", 64'(cons_gnt), 64'd0);
      step();
      drive(0, 0, 0, 0, 0);
      #1 chk("t2_gnt_t2", 64'(cons_gnt), 64'd1);
      chk("t2_len", 64'(cons_len), 64'd2);
      step();
      cyc(0, 0, 0, 1, 0);
      $display("scenario 2 done");

      // Scenario 3: both buffers full stall the writer until a release
      do_reset(1'b0);
      for (int i = 0; i < 6; i++) cyc(1, (i % 3) == 2, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      #1 chk("t3_stalled", 64'(wr_ready), 64'd0);
      step();
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0);
      #1 chk("t3_ready_again", 64'(wr_ready), 64'd1);
      chk("t3_addr", 64'(mem_waddr), 64'd0);
      step();
      $display("scenario 3 done");

      // Scenario 4: overflow forces a close without last
      do_reset(1'b0);
      for (int i = 0; i < NWORD; i++) cyc(1, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0);
      #1 chk("t4_err0", 64'(err), 64'h1);
      chk("t4_addr", 64'(mem_waddr), 64'(NWORD));
      step();
      drive(0, 0, 0, 0, 0);
      #1 chk("t4_len", 64'(cons_len), 64'(NWORD));
      step();
      $display("scenario 4 done");

      // Scenario 5: stray release sets err[1]; flush clears everything
      do_reset(1'b0);
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0);
      #1 chk("t5_err1", 64'(err), 64'h2);
      chk("t5_state", 64'(buf_state), 64'h2);
      step();
      cyc(1, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      #1 chk("t5_flush_err", 64'(err), 64'h0);
      chk("t5_flush_state", 64'(buf_state), 64'h0);
      step();
      $display("scenario 5 done");

`ifdef PINGPONG_PERF_CNT_EN
      // Scenario 6: five stalled write cycles with both buffers full
      do_reset(1'b0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      #1 chk("t6_wr_stall", 64'(wr_stall_cnt), 64'd5);
      step();
      $display("scenario 6 done");
`endif

      // Random traffic
      do_reset(1'b0);
      req_r = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         req_r = m_gnt ? 1'b0 : (req_r || ($urandom_range(2) == 0));
         if (busy_idx() >= 0) dn_r = ($urandom_range(3) == 0);
         else dn_r = ($urandom_range(59) == 0);
         cyc($urandom_range(3) != 0, $urandom_range(5) == 0, req_r, dn_r,
             $urandom_range(499) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
